// File: rtl/ctrl_decode_stage_pkg.sv
// Shared types for the registered RV32 control decode stage.
package ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // Widest GPIO bank the decoder can address; the stage slices down to NUM_GPIO.
  localparam int GPIO_MAX = 16;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_ADD   = 4'b0011,
    ALU_SUB   = 4'b0100,
    ALU_MUL   = 4'b0101,
    ALU_MULH  = 4'b0110,
    ALU_MULHU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101
  } aluop_e;

  typedef enum logic [1:0] {
    SEL_GPIO = 2'd0,
    SEL_IMMU = 2'd1,
    SEL_ALU  = 2'd2
  } regsel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_MUL   = 2'd2
  } st_e;

  typedef struct packed {
    logic                alusrc;
    logic                regwrite;
    regsel_e             regsel;
    aluop_e              aluop;
    logic [GPIO_MAX-1:0] gpio_we;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Fetch-side handshake plus decoded control bundle presented to execute.
interface ctrl_decode_stage_if #(
  parameter int NUM_GPIO = 1
) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic                out_valid;
  logic                out_ready;
  logic                alusrc;
  logic                regwrite;
  logic [1:0]          regsel;
  logic [3:0]          aluop;
  logic [NUM_GPIO-1:0] gpio_we;
  logic                illegal;
  logic                mul_busy;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alusrc, regwrite, regsel, aluop, gpio_we, illegal, mul_busy
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alusrc, regwrite, regsel, aluop, gpio_we, illegal, mul_busy
  );
endinterface

// File: rtl/ctrl_decode_stage_decode.sv
// Combinational RV32 decode table: instr -> ctrl_t plus a multiply flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int          NUM_GPIO      = 1,
  parameter logic [11:0] GPIO_CSR_BASE = 12'hF00
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_is_mul
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [11:0] w_csr;
  logic [11:0] w_off;
  logic        w_in_range;
  logic        w_legal;
  logic        w_is_mul;
  ctrl_t       w_ctrl;
  logic        w_unused;

  assign w_op  = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_csr = i_instr[31:20];
  assign w_off = w_csr - GPIO_CSR_BASE;
  // Offset compare avoids overflow of BASE+NUM_GPIO near the top of CSR space.
  assign w_in_range = (w_csr >= GPIO_CSR_BASE) && ({20'd0, w_off} < 32'(NUM_GPIO));
  assign w_unused   = ^{i_instr[19:15], i_instr[11:7]};

  always_comb begin
    w_ctrl   = '0;
    w_legal  = 1'b1;
    w_is_mul = 1'b0;
    case (w_op)
      OP_R: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = SEL_ALU;
        case (w_f7)
          7'b0000000: begin
            case (w_f3)
              3'b000: w_ctrl.aluop = ALU_ADD;
              3'b111: w_ctrl.aluop = ALU_AND;
              3'b110: w_ctrl.aluop = ALU_OR;
              3'b100: w_ctrl.aluop = ALU_XOR;
              3'b001: w_ctrl.aluop = ALU_SLL;
              3'b101: w_ctrl.aluop = ALU_SRL;
              3'b010: w_ctrl.aluop = ALU_SLT;
              default: w_ctrl.aluop = ALU_SLTU;
            endcase
          end
          7'b0100000: begin
            case (w_f3)
              3'b000:  w_ctrl.aluop = ALU_SUB;
              3'b101:  w_ctrl.aluop = ALU_SRA;
              default: w_legal = 1'b0;
            endcase
          end
          7'b0000001: begin
            w_is_mul = 1'b1;
            case (w_f3)
              3'b000:  w_ctrl.aluop = ALU_MUL;
              3'b001:  w_ctrl.aluop = ALU_MULH;
              3'b011:  w_ctrl.aluop = ALU_MULHU;
              default: w_legal = 1'b0;
            endcase
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regsel   = SEL_ALU;
        case (w_f3)
          3'b000: w_ctrl.aluop = ALU_ADD;
          3'b111: w_ctrl.aluop = ALU_AND;
          3'b110: w_ctrl.aluop = ALU_OR;
          3'b100: w_ctrl.aluop = ALU_XOR;
          3'b010: w_ctrl.aluop = ALU_SLT;
          3'b011: w_ctrl.aluop = ALU_SLTU;
          3'b001: begin
            w_ctrl.aluop = ALU_SLL;
            if (w_f7 != 7'b0000000) w_legal = 1'b0;
          end
          default: begin
            if (w_f7 == 7'b0000000)      w_ctrl.aluop = ALU_SRL;
            else if (w_f7 == 7'b0100000) w_ctrl.aluop = ALU_SRA;
            else                         w_legal = 1'b0;
          end
        endcase
      end
      OP_LUI: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = SEL_IMMU;
      end
      OP_SYS: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regsel   = SEL_GPIO;
        if (w_f3 == 3'b001 && w_in_range) w_ctrl.gpio_we[w_off[3:0]] = 1'b1;
        else                              w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    // Anything outside the table becomes a pure illegal marker with no side effects.
    if (!w_legal) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
      w_is_mul       = 1'b0;
    end
  end

  assign o_ctrl   = w_ctrl;
  assign o_is_mul = w_is_mul;

endmodule

// File: rtl/ctrl_decode_stage.sv
// One-entry registered decode stage with multiply stall between fetch and execute.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int          NUM_GPIO      = 1,
  parameter logic [11:0] GPIO_CSR_BASE = 12'hF00,
  parameter int          MUL_CYCLES    = 3
) (
  input logic                clk,
  input logic                rst,
  ctrl_decode_stage_if.slave bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  st_e         r_state;
  st_e         w_next;
  logic [CW-1:0] r_cnt;
  ctrl_t       r_ctrl;
  ctrl_t       w_dec;
  logic        w_is_mul;
  logic        w_mul_go;
  logic        w_accept;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_mul_busy;
  logic        w_unused_gpio;

  ctrl_decode #(
    .NUM_GPIO     (NUM_GPIO),
    .GPIO_CSR_BASE(GPIO_CSR_BASE)
  ) u_dec (
    .i_instr (bus.instr),
    .o_ctrl  (w_dec),
    .o_is_mul(w_is_mul)
  );

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_mul_go = w_is_mul && (MUL_CYCLES > 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY, ST_FULL: begin
        if (w_accept)                             w_next = w_mul_go ? ST_MUL : ST_FULL;
        else if (r_state == ST_FULL && bus.out_ready) w_next = ST_EMPTY;
      end
      ST_MUL:  if (r_cnt == CW'(1)) w_next = ST_FULL;
      default: w_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_mul_busy  = 1'b0;
    case (r_state)
      ST_EMPTY: w_in_ready = 1'b1;
      ST_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      ST_MUL:   w_mul_busy = 1'b1;
      default:  w_in_ready = 1'b0;
    endcase
  end

  // Controls only change on accept, so they stay frozen through stalls and back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_ctrl <= w_dec;
      r_cnt  <= w_mul_go ? CW'(MUL_CYCLES - 1) : '0;
    end else if (r_state == ST_MUL && r_cnt != '0) begin
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  assign w_unused_gpio = ^r_ctrl.gpio_we;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.mul_busy  = w_mul_busy;
  assign bus.alusrc    = r_ctrl.alusrc;
  assign bus.regwrite  = r_ctrl.regwrite;
  assign bus.regsel    = r_ctrl.regsel;
  assign bus.aluop     = r_ctrl.aluop;
  assign bus.gpio_we   = r_ctrl.gpio_we[NUM_GPIO-1:0];
  assign bus.illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed-vector bench: one stage with a 3-cycle multiply, one with a 1-cycle multiply.
module tb_ctrl_decode_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  ctrl_decode_stage_if #(.NUM_GPIO(2)) ifa ();
  ctrl_decode_stage_if #(.NUM_GPIO(2)) ifb ();

  ctrl_decode_stage #(.NUM_GPIO(2), .GPIO_CSR_BASE(12'hF00), .MUL_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  ctrl_decode_stage #(.NUM_GPIO(2), .GPIO_CSR_BASE(12'hF00), .MUL_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic [31:0] ins);
    ifa.in_valid = 1'b1;
    ifa.instr    = ins;
    tick();
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    ifa.in_valid = 1'b0; ifa.instr = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.instr = '0; ifb.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_in_ready",  32'(ifa.in_ready),  1);
    chk("rst_mul_busy",  32'(ifa.mul_busy),  0);
    chk("rst_ctrl",      32'({ifa.alusrc, ifa.regwrite, ifa.regsel, ifa.aluop, ifa.gpio_we, ifa.illegal}), 0);
    rst = 1'b0;

    // add then back-to-back sub with execute always ready
    offer_a(32'h002081B3);
    chk("add_valid",    32'(ifa.out_valid), 1);
    chk("add_aluop",    32'(ifa.aluop),     4'b0011);
    chk("add_regsel",   32'(ifa.regsel),    2);
    chk("add_regwrite", 32'(ifa.regwrite),  1);
    chk("add_alusrc",   32'(ifa.alusrc),    0);
    ifa.in_valid = 1'b1;
    ifa.instr    = 32'h402081B3;
    #1;
    chk("full_rdy", 32'(ifa.in_ready), 1);
    tick();
    ifa.in_valid = 1'b0;
    chk("sub_valid", 32'(ifa.out_valid), 1);
    chk("sub_aluop", 32'(ifa.aluop),     4'b0100);
    tick();
    chk("drain_empty", 32'(ifa.out_valid), 0);

    // multiply stalls for MUL_CYCLES-1 cycles
    offer_a(32'h022081B3);
    chk("mul_w1_busy",  32'(ifa.mul_busy),  1);
    chk("mul_w1_rdy",   32'(ifa.in_ready),  0);
    chk("mul_w1_valid", 32'(ifa.out_valid), 0);
    tick();
    chk("mul_w2_busy",  32'(ifa.mul_busy),  1);
    chk("mul_w2_rdy",   32'(ifa.in_ready),  0);
    tick();
    chk("mul_done_valid", 32'(ifa.out_valid), 1);
    chk("mul_done_busy",  32'(ifa.mul_busy),  0);
    chk("mul_aluop",      32'(ifa.aluop),     4'b0101);

    // GPIO CSRs and the rest of the decode table, replacing in FULL each cycle
    offer_a(32'hF00110F3);
    chk("csr0_we",     32'(ifa.gpio_we),  2'b01);
    chk("csr0_regsel", 32'(ifa.regsel),   0);
    chk("csr0_rw",     32'(ifa.regwrite), 1);
    offer_a(32'hF01110F3);
    chk("csr1_we",  32'(ifa.gpio_we), 2'b10);
    chk("csr1_ill", 32'(ifa.illegal), 0);
    offer_a(32'hF02110F3);
    chk("csr2_ill", 32'(ifa.illegal),  1);
    chk("csr2_we",  32'(ifa.gpio_we),  2'b00);
    chk("csr2_rw",  32'(ifa.regwrite), 0);
    offer_a(32'h00F17093);
    chk("andi_aluop",  32'(ifa.aluop),  4'b0000);
    chk("andi_alusrc", 32'(ifa.alusrc), 1);
    offer_a(32'h4020D093);
    chk("srai_aluop", 32'(ifa.aluop), 4'b1010);
    offer_a(32'h02009093);
    chk("slli_bad_ill", 32'(ifa.illegal), 1);
    offer_a(32'h123452B7);
    chk("lui_regsel", 32'(ifa.regsel),   1);
    chk("lui_rw",     32'(ifa.regwrite), 1);
    chk("lui_ill",    32'(ifa.illegal),  0);
    offer_a(32'h0000007F);
    chk("bad_ill",   32'(ifa.illegal),   1);
    chk("bad_rw",    32'(ifa.regwrite),  0);
    chk("bad_valid", 32'(ifa.out_valid), 1);
    tick();

    // back-pressure: add held for 5 cycles while sub waits
    offer_a(32'h002081B3);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.instr     = 32'h402081B3;
    #1;
    chk("bp_rdy", 32'(ifa.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ifa.out_valid), 1);
      chk("bp_aluop", 32'(ifa.aluop),     4'b0011);
      chk("bp_rdy_h", 32'(ifa.in_ready),  0);
    end
    ifa.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(ifa.in_ready), 1);
    tick();
    ifa.in_valid = 1'b0;
    chk("bp_sub_aluop", 32'(ifa.aluop), 4'b0100);
    tick();

    // reset in the middle of a multiply
    offer_a(32'h022081B3);
    chk("rm_busy", 32'(ifa.mul_busy), 1);
    rst = 1'b1;
    tick();
    chk("rm_valid", 32'(ifa.out_valid), 0);
    chk("rm_busy0", 32'(ifa.mul_busy),  0);
    chk("rm_rdy",   32'(ifa.in_ready),  1);
    chk("rm_ctrl",  32'({ifa.alusrc, ifa.regwrite, ifa.regsel, ifa.aluop, ifa.gpio_we, ifa.illegal}), 0);
    rst = 1'b0;
    tick();

    // single-cycle multiply: no stall at all
    ifb.in_valid = 1'b1;
    ifb.instr    = 32'h022081B3;
    #1;
    chk("m1_rdy", 32'(ifb.in_ready), 1);
    tick();
    ifb.in_valid = 1'b0;
    chk("m1_valid", 32'(ifb.out_valid), 1);
    chk("m1_busy",  32'(ifb.mul_busy),  0);
    chk("m1_aluop", 32'(ifb.aluop),     4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, parametrised successor to the core's combinational control decoder.
- Accepts a 32-bit RV32 instruction over a valid/ready handshake and decodes it into ALU, register-file and GPIO control signals.
- Presents the decoded controls from a one-entry pipeline register.
- Adds N CSR-mapped GPIO output channels, illegal-instruction flagging and multi-cycle multiply stalling. Sits between fetch and execute.

Parameters:
- NUM_GPIO, 1, number of CSR-mapped GPIO output channels (1..16).
- GPIO_CSR_BASE, 12'hF00, CSR address of GPIO channel 0; channel k is at GPIO_CSR_BASE+k.
- MUL_CYCLES, 3, total cycles a mul/mulh/mulhu occupies the stage (>=1).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instr is valid.
- in_ready  output  1  stage can accept instr this cycle.
- instr  input  32  raw instruction.
- out_valid  output  1  decoded controls valid.
- out_ready  input  1  execute consumes controls this cycle.
- alusrc  output  1  0 = rs2, 1 = immediate.
- regwrite  output  1  write-back enable.
- regsel  output  2  0 = GPIO_in, 1 = imm_U, 2 = ALU result.
- aluop  output  4  ALU operation code.
- gpio_we  output  NUM_GPIO  one-hot GPIO channel write enable.
- illegal  output  1  instruction not in the decode table.
- mul_busy  output  1  multiply countdown in progress.

Behaviour:
- Reset: all outputs 0 except in_ready, which is 1 after reset. State EMPTY; counter 0.
- Reset has priority over every other event, including one mid-multiply; any held entry is discarded.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1.
  - MUL_WAIT: out_valid=0, in_ready=0, mul_busy=1.
- Accept when in_valid && in_ready; decoded controls are registered on that edge (latency 1).
- On accept from EMPTY, or from FULL with out_ready=1 (same-cycle replace, full throughput):
  - go to MUL_WAIT with counter=MUL_CYCLES-1 if the instruction is a multiply and MUL_CYCLES>1;
  - otherwise go to FULL.
- FULL with out_ready=1 and no accept: go to EMPTY.
- in_ready is 1 in EMPTY, and is equal to out_ready in FULL.
- MUL_WAIT: counter decrements each cycle; at counter==1 the next state is FULL. Controls remain held and stable throughout.
- FULL with out_ready=0: all outputs held stable.
- Decode table: default every control 0.
  - R-type (0110011), regwrite=1, regsel=2:
    - funct7=0000000: add 0011, and 0000, or 0001, xor 0010, sll 1000, srl 1001, slt 1100, sltu 1101.
    - funct7=0100000: sub 0100, sra 1010.
    - funct7=0000001: mul 0101, mulh 0110, mulhu 0111.
  - I-type (0010011), regwrite=1, alusrc=1, regsel=2:
    - addi 0011, andi 0000, ori 0001, xori 0010, slti 1100, sltiu 1101.
    - slli 1000, legal only with imm[11:5]=0000000.
    - srli 1001 with imm[11:5]=0000000; srai 1010 with imm[11:5]=0100000.
  - U-type lui (0110111): regwrite=1, regsel=1.
  - csrrw (1110011, funct3=001), regwrite=1, regsel=0:
    - with GPIO_CSR_BASE <= csr < GPIO_CSR_BASE+NUM_GPIO: gpio_we bit (csr-GPIO_CSR_BASE) is set.
    - any other CSR: illegal.
  - Any other encoding: illegal=1 and all other controls 0. It still flows through the handshake as a normal FULL entry.
- gpio_we, regwrite and illegal are meaningful only while out_valid=1. Execute qualifies them with out_valid && out_ready.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams: OP_R, OP_I, OP_LUI, OP_SYS;
  - the aluop enum: ALU_AND through ALU_SLTU;
  - the regsel enum: SEL_GPIO, SEL_IMMU, SEL_ALU;
  - a ctrl_t struct bundling alusrc, regwrite, regsel, aluop, gpio_we and illegal.
- One combinational sub-module, ctrl_decode, maps instr to ctrl_t and an is_mul flag.
- ctrl_decode_stage wraps ctrl_decode with the state machine and pipeline register.

Test Plan:
- Reset, then add 0x002081B3 with out_ready=1: next cycle out_valid=1, aluop=0011, regsel=2, regwrite=1. Back-to-back sub 0x402081B3 is accepted the same cycle and gives aluop=0100.
- mul 0x022081B3 with MUL_CYCLES=3: in_ready=0 and mul_busy=1 for 2 cycles, then out_valid=1 with aluop=0101. Rerun with MUL_CYCLES=1: no stall.
- NUM_GPIO=2: csrrw 0xF00110F3 gives gpio_we=01; 0xF01110F3 gives gpio_we=10. CSR 0xF02 gives illegal=1 and gpio_we=00.
- andi 0x00F17093 gives aluop=0000 and alusrc=1. lui 0x123452B7 gives regsel=1 and regwrite=1. Opcode 0x0000007F gives illegal=1 and regwrite=0.
- Hold out_ready=0 for 5 cycles after add: outputs stable, in_ready=0, and the offered instr is not accepted until out_ready=1.
- Assert rst during MUL_WAIT: next cycle out_valid=0, mul_busy=0, in_ready=1, all controls 0.
